serial_tx: RTL

Serializer for the SerDes link: accepts 32-bit parallel words over a valid/ready handshake and shifts each one out LSB-first as a 64-bit framed packet on a single serial line at the 32 MHz serial clock. Each packet is built from four pad bytes interleaved with four data bytes. The block also generates the nominal 1 MHz parallel clock, which the far-end deserializer PLL synchronizes to. It is the transmit end of the link whose receive end contains the PLL/VFO and the deserializer.

---
 rtl/serial_tx_pkg.sv | 19 +
 rtl/serial_tx_par_clk_gen.sv | 23 ++
 rtl/serial_tx.sv | 103 ++++++++++
 3 files changed

// File: rtl/serial_tx_pkg.sv
// Shared constants, state encoding and pad-byte helper for the serial_tx serializer.
// SERIAL_TX_PARITY_EN (optional) puts the data byte's even parity into pad bit 7.
package serial_tx_pkg;

  localparam int FrameBits = 64;
  localparam int ParClkDiv = 32;
  localparam logic [7:0] PadBase = 8'h00;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // msb is the parity bit when parity is enabled, otherwise 0.
  function automatic logic [7:0] pad_byte(input logic [1:0] slot, input logic msb);
    pad_byte = PadBase | {msb, 5'b0, slot};
  endfunction

endpackage

// File: rtl/serial_tx_par_clk_gen.sv
// Free-running divide-by-ParClkDiv producing the 50% duty parallel clock.
// Independent of the packet FSM; only the synchronous reset touches it.
module serial_tx_par_clk_gen
  import serial_tx_pkg::*;
(
  input  logic ClockIn,
  input  logic Reset,
  output logic ParClkOut
);

  localparam int DivW = $clog2(ParClkDiv);

  logic [DivW-1:0] div;

  always_ff @(posedge ClockIn) begin
    if (Reset) div <= '0;
    else       div <= div + 1'b1;
  end

  // MSB of the counter is high for the second half of each period.
  assign ParClkOut = div[DivW-1];

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial framer: 32-bit words out LSB-first as 64-bit packets of
// interleaved pad/data bytes. SERIAL_TX_PARITY_EN enables pad-byte parity.
module serial_tx
  import serial_tx_pkg::*;
(
  input  logic        ClockIn,
  input  logic        Reset,
  input  logic [31:0] ParData,
  input  logic        ParValid,
  output logic        ParReady,
  output logic        SerOut,
  output logic        SerValid,
  output logic        FrameDone,
  output logic        ParClkOut,
  output state_t      State
);

  localparam int CntW = $clog2(FrameBits);
  localparam logic [CntW-1:0] LastBit = CntW'(FrameBits - 1);

  state_t          state;
  logic [CntW-1:0] bit_cnt;
  logic [31:0]     word;
  logic [1:0]      slot;
  logic [7:0]      data_byte;
  logic [7:0]      cur_byte;
  logic            pad_msb;
  logic            cur_bit;
  logic            accept;

  // Handshake: a word transfers on any rising edge where ParValid and ParReady
  // are both high. ParReady is registered and is high in IDLE and while the
  // counter sits on the last bit, so a waiting word follows with no gap.
  assign accept = ParValid && ParReady;

  assign slot      = bit_cnt[5:4];
  assign data_byte = word[{slot, 3'b000} +: 8];

`ifdef SERIAL_TX_PARITY_EN
  assign pad_msb = ^data_byte;
`else
  assign pad_msb = 1'b0;
`endif

  assign cur_byte = bit_cnt[3] ? data_byte : pad_byte(slot, pad_msb);
  assign cur_bit  = cur_byte[bit_cnt[2:0]];

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      word      <= '0;
      ParReady  <= 1'b0;
      SerOut    <= 1'b0;
      SerValid  <= 1'b0;
      FrameDone <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          SerOut    <= 1'b0;
          SerValid  <= 1'b0;
          FrameDone <= 1'b0;
          if (accept) begin
            word     <= ParData;
            bit_cnt  <= '0;
            state    <= SEND;
            ParReady <= 1'b0;
          end else begin
            ParReady <= 1'b1;
          end
        end
        SEND: begin
          SerOut    <= cur_bit;
          SerValid  <= 1'b1;
          FrameDone <= (bit_cnt == LastBit);
          if (bit_cnt == LastBit) begin
            bit_cnt <= '0;
            if (accept) begin
              word     <= ParData;
              ParReady <= 1'b0;
            end else begin
              state    <= IDLE;
              ParReady <= 1'b1;
            end
          end else begin
            bit_cnt  <= bit_cnt + 1'b1;
            ParReady <= (bit_cnt == LastBit - 1'b1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign State = state;

  serial_tx_par_clk_gen par_clk_gen (
    .ClockIn  (ClockIn),
    .Reset    (Reset),
    .ParClkOut(ParClkOut)
  );

endmodule
